// File: rtl/serial_parity_rx.sv
// Serial frame receiver: start(0), DATA_W data bits LSB first, parity, stop(1).
// Rebuilds the word, checks parity and stop bit, and keeps a saturating error count.
module serial_parity_rx #(
    parameter int DATA_W     = 8,
    parameter bit PARITY_ODD = 1'b0,
    parameter int ERRCNT_W   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sin,
    input  logic                sin_valid,
    input  logic                clr_errcnt,
    output logic [DATA_W-1:0]   dout,
    output logic                dout_valid,
    output logic                parity_err,
    output logic                frame_err,
    output logic                busy,
    output logic [ERRCNT_W-1:0] err_count
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t             state, state_nxt;
    logic [DATA_W-1:0]  shreg;
    logic [CNT_W-1:0]   cnt;
    logic               pbit;

    function automatic logic [ERRCNT_W-1:0] sat_inc(input logic [ERRCNT_W-1:0] v);
        return (&v) ? v : v + ERRCNT_W'(1);
    endfunction

    function automatic logic parity_bad(input logic [DATA_W-1:0] d, input logic p);
        return (^d ^ p) != PARITY_ODD;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (sin_valid) begin
            case (state)
                IDLE:    if (!sin) state_nxt = DATA;
                DATA:    if (cnt == LAST_BIT) state_nxt = PARITY;
                PARITY:  state_nxt = STOP;
                STOP:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg      <= '0;
            cnt        <= '0;
            pbit       <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
            err_count  <= '0;
        end else begin
            dout_valid <= sin_valid && (state == STOP);
            busy       <= (state_nxt != IDLE);
            if (sin_valid) begin
                case (state)
                    IDLE: cnt <= '0;
                    DATA: begin
                        shreg <= {sin, shreg[DATA_W-1:1]};
                        cnt   <= (cnt == LAST_BIT) ? '0 : cnt + CNT_W'(1);
                    end
                    PARITY: pbit <= sin;
                    STOP: begin
                        dout       <= shreg;
                        parity_err <= parity_bad(shreg, pbit);
                        frame_err  <= ~sin;
                    end
                    default: ;
                endcase
            end
            // Error flags are already registered when dout_valid is high, so count here.
            if (clr_errcnt)
                err_count <= '0;
            else if (dout_valid && (parity_err || frame_err))
                err_count <= sat_inc(err_count);
        end
    end

endmodule

// File: tb/tb_serial_parity_rx.sv
// Randomized bench for serial_parity_rx: even- and odd-parity instances share stimulus,
// each checked against a frame-level reference model.
module tb_serial_parity_rx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, sin, sin_valid, clr_errcnt;
    logic [7:0] dout_e, dout_o;
    logic       dv_e, dv_o, pe_e, pe_o, fe_e, fe_o, busy_e, busy_o;
    logic [3:0] ec_e, ec_o;

    serial_parity_rx #(.DATA_W(8), .PARITY_ODD(1'b0), .ERRCNT_W(4)) dut_e (
        .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .clr_errcnt(clr_errcnt),
        .dout(dout_e), .dout_valid(dv_e), .parity_err(pe_e), .frame_err(fe_e),
        .busy(busy_e), .err_count(ec_e)
    );

    serial_parity_rx #(.DATA_W(8), .PARITY_ODD(1'b1), .ERRCNT_W(4)) dut_o (
        .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .clr_errcnt(clr_errcnt),
        .dout(dout_o), .dout_valid(dv_o), .parity_err(pe_o), .frame_err(fe_o),
        .busy(busy_o), .err_count(ec_o)
    );

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } ev_t;

    ev_t exp_e[$], exp_o[$];
    int  dvc_e[$], dvc_o[$];
    int  ecnt_e = 0, ecnt_o = 0;
    int  n_cmp = 0, n_bad = 0;
    int  cyc = 0;
    ev_t me;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every dout_valid pulse must match the oldest expected frame.
    initial forever begin
        @(negedge clk);
        if (dv_e === 1'b1) begin
            dvc_e.push_back(cyc);
            n_cmp++;
            if (exp_e.size() == 0) begin
                n_bad++;
                $display("FAIL spurious_dv_even: got dout=%h with nothing expected", dout_e);
            end else begin
                me = exp_e.pop_front();
                if ({dout_e, pe_e, fe_e} !== {me.d, me.pe, me.fe}) begin
                    n_bad++;
                    $display("FAIL frame_even: got d=%h pe=%b fe=%b, want d=%h pe=%b fe=%b",
                             dout_e, pe_e, fe_e, me.d, me.pe, me.fe);
                end
            end
        end
        if (dv_o === 1'b1) begin
            dvc_o.push_back(cyc);
            n_cmp++;
            if (exp_o.size() == 0) begin
                n_bad++;
                $display("FAIL spurious_dv_odd: got dout=%h with nothing expected", dout_o);
            end else begin
                me = exp_o.pop_front();
                if ({dout_o, pe_o, fe_o} !== {me.d, me.pe, me.fe}) begin
                    n_bad++;
                    $display("FAIL frame_odd: got d=%h pe=%b fe=%b, want d=%h pe=%b fe=%b",
                             dout_o, pe_o, fe_o, me.d, me.pe, me.fe);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic int sat15(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    // Reference model: count the ones in data+parity; even total is correct for
    // even parity, odd total is correct for odd parity.
    task automatic expect_frame(input logic [7:0] d, input logic pb, input logic sb);
        ev_t m;
        int  ones;
        ones = $countones(d) + int'(pb);
        m.d  = d;
        m.fe = ~sb;
        m.pe = (ones % 2) != 0;
        exp_e.push_back(m);
        if (m.pe || m.fe) ecnt_e = sat15(ecnt_e + 1);
        m.pe = (ones % 2) == 0;
        exp_o.push_back(m);
        if (m.pe || m.fe) ecnt_o = sat15(ecnt_o + 1);
    endtask

    // Called at a negedge; idles for gap cycles with a random line, then strobes one bit.
    task automatic send_bit(input logic b, input int gap);
        repeat (gap) begin
            sin_valid = 1'b0;
            sin       = 1'($urandom);
            @(negedge clk);
        end
        sin       = b;
        sin_valid = 1'b1;
        @(negedge clk);
        sin_valid = 1'b0;
    endtask

    function automatic int pick_gap(input int maxgap);
        return (maxgap == 0) ? 0 : int'($urandom_range(maxgap, 0));
    endfunction

    task automatic send_frame(input logic [7:0] d, input logic pb, input logic sb, input int maxgap);
        expect_frame(d, pb, sb);
        send_bit(1'b0, pick_gap(maxgap));
        for (int i = 0; i < 8; i++) send_bit(d[i], pick_gap(maxgap));
        send_bit(pb, pick_gap(maxgap));
        send_bit(sb, pick_gap(maxgap));
    endtask

    task automatic flush();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; clr_errcnt = 1'b0; sin = 1'b0; sin_valid = 1'b1;
        repeat (4) @(negedge clk);
        n_cmp++;
        if ({dout_e, dv_e, pe_e, fe_e, busy_e, ec_e} !== 16'h0) begin
            n_bad++;
            $display("FAIL reset_even: got %h, want 0", {dout_e, dv_e, pe_e, fe_e, busy_e, ec_e});
        end
        n_cmp++;
        if ({dout_o, dv_o, pe_o, fe_o, busy_o, ec_o} !== 16'h0) begin
            n_bad++;
            $display("FAIL reset_odd: got %h, want 0", {dout_o, dv_o, pe_o, fe_o, busy_o, ec_o});
        end
        sin_valid = 1'b0; sin = 1'b1; rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [7:0] d;
        d = 8'hA5;
        expect_frame(d, 1'b0, 1'b1);
        send_bit(1'b0, 0);
        n_cmp++;
        if (busy_e !== 1'b1) begin n_bad++; $display("FAIL busy_after_start: got %b, want 1", busy_e); end
        for (int i = 0; i < 8; i++) send_bit(d[i], 0);
        send_bit(1'b0, 0);
        n_cmp++;
        if (busy_e !== 1'b1) begin n_bad++; $display("FAIL busy_in_stop: got %b, want 1", busy_e); end
        send_bit(1'b1, 0);
        n_cmp++;
        if ({dv_e, busy_e} !== 2'b10) begin
            n_bad++;
            $display("FAIL valid_latency: got dv=%b busy=%b, want dv=1 busy=0", dv_e, busy_e);
        end
        flush();
        n_cmp++;
        if ({dout_e, pe_e, fe_e, ec_e} !== {8'hA5, 1'b0, 1'b0, 4'd0}) begin
            n_bad++;
            $display("FAIL basic_hold: got d=%h pe=%b fe=%b ec=%0d, want A5 0 0 0", dout_e, pe_e, fe_e, ec_e);
        end
    endtask

    task automatic test_parity_err();
        send_frame(8'hA5, 1'b1, 1'b1, 0);
        flush();
        n_cmp++;
        if ({pe_e, fe_e, ec_e} !== {1'b1, 1'b0, 4'(ecnt_e)}) begin
            n_bad++;
            $display("FAIL parity_err: got pe=%b fe=%b ec=%0d, want 1 0 %0d", pe_e, fe_e, ec_e, ecnt_e);
        end
        send_frame(8'hA5, 1'b0, 1'b0, 0);
        flush();
        n_cmp++;
        if ({pe_e, fe_e, ec_e} !== {1'b0, 1'b1, 4'd2}) begin
            n_bad++;
            $display("FAIL frame_err: got pe=%b fe=%b ec=%0d, want 0 1 2", pe_e, fe_e, ec_e);
        end
    endtask

    task automatic test_gaps();
        logic [7:0] d;
        repeat (5) send_bit(1'b1, pick_gap(3));
        send_frame(8'h3C, 1'b0, 1'b1, 3);
        flush();
        n_cmp++;
        if ({exp_e.size(), dout_e} !== {32'd0, 8'h3C}) begin
            n_bad++;
            $display("FAIL gapped_3c: pending=%0d d=%h, want 0 3C", exp_e.size(), dout_e);
        end
        for (int k = 0; k < 12; k++) begin
            d = 8'($urandom);
            repeat ($urandom_range(2, 0)) send_bit(1'b1, pick_gap(3));
            send_frame(d, 1'($urandom), ($urandom_range(3, 0) != 0), 3);
        end
        flush();
        n_cmp++;
        if (exp_e.size() + exp_o.size() != 0) begin
            n_bad++;
            $display("FAIL random_missing: pending even=%0d odd=%0d, want 0", exp_e.size(), exp_o.size());
        end
        n_cmp++;
        if ({ec_e, ec_o} !== {4'(ecnt_e), 4'(ecnt_o)}) begin
            n_bad++;
            $display("FAIL random_errcnt: got %0d/%0d, want %0d/%0d", ec_e, ec_o, ecnt_e, ecnt_o);
        end
    endtask

    task automatic test_reset_mid();
        send_bit(1'b0, 0);
        for (int i = 0; i < 4; i++) send_bit(1'($urandom), 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ecnt_e = 0; ecnt_o = 0;
        n_cmp++;
        if ({busy_e, ec_e, dv_e} !== 6'd0) begin
            n_bad++;
            $display("FAIL reset_mid: got busy=%b ec=%0d dv=%b, want 0 0 0", busy_e, ec_e, dv_e);
        end
        send_frame(8'h81, 1'b0, 1'b1, 0);
        flush();
        n_cmp++;
        if ({exp_e.size(), dout_e, pe_e} !== {32'd0, 8'h81, 1'b0}) begin
            n_bad++;
            $display("FAIL after_abort: pending=%0d d=%h pe=%b, want 0 81 0", exp_e.size(), dout_e, pe_e);
        end
    endtask

    task automatic test_saturate();
        logic [7:0] d;
        clr_errcnt = 1'b1;
        @(negedge clk);
        clr_errcnt = 1'b0;
        ecnt_e = 0; ecnt_o = 0;
        for (int k = 0; k < 20; k++) begin
            d = 8'($urandom);
            send_frame(d, ~(^d), 1'b1, 0);
            @(negedge clk);
            n_cmp++;
            if (ec_e !== 4'(ecnt_e)) begin
                n_bad++;
                $display("FAIL errcnt_step%0d: got %0d, want %0d", k, ec_e, ecnt_e);
            end
        end
        n_cmp++;
        if (ec_e !== 4'd15) begin n_bad++; $display("FAIL errcnt_sat: got %0d, want 15", ec_e); end
        d = 8'($urandom);
        send_frame(d, ~(^d), 1'b1, 0);
        clr_errcnt = 1'b1;
        n_cmp++;
        if (dv_e !== 1'b1) begin n_bad++; $display("FAIL clr_overlap_dv: got dv=%b, want 1", dv_e); end
        @(negedge clk);
        clr_errcnt = 1'b0;
        ecnt_e = 0; ecnt_o = 0;
        n_cmp++;
        if ({ec_e, ec_o} !== 8'd0) begin
            n_bad++;
            $display("FAIL clr_priority: got %0d/%0d, want 0/0", ec_e, ec_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        send_frame(8'h00, 1'b1, 1'b1, 0);
        flush();
        n_cmp++;
        if ({pe_o, pe_e} !== 2'b01) begin
            n_bad++;
            $display("FAIL odd_zero: got pe_odd=%b pe_even=%b, want 0 1", pe_o, pe_e);
        end
        d = 8'($urandom);
        send_frame(d, ~(^d), 1'b1, 0);
        d = 8'($urandom);
        send_frame(d, ~(^d), 1'b1, 0);
        flush();
        n_cmp++;
        if (dvc_o.size() < 2 || exp_o.size() != 0) begin
            n_bad++;
            $display("FAIL b2b_count: pulses=%0d pending=%0d", dvc_o.size(), exp_o.size());
        end else if (dvc_o[dvc_o.size()-1] - dvc_o[dvc_o.size()-2] != 11) begin
            n_bad++;
            $display("FAIL b2b_spacing: got %0d cycles, want 11",
                     dvc_o[dvc_o.size()-1] - dvc_o[dvc_o.size()-2]);
        end
        n_cmp++;
        if ({ec_e, ec_o} !== {4'(ecnt_e), 4'(ecnt_o)}) begin
            n_bad++;
            $display("FAIL b2b_errcnt: got %0d/%0d, want %0d/%0d", ec_e, ec_o, ecnt_e, ecnt_o);
        end
    endtask

    initial begin
        rst = 1'b1; sin = 1'b1; sin_valid = 1'b0; clr_errcnt = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_parity_err();
        test_gaps();
        test_reset_mid();
        test_saturate();
        test_back_to_back();
        flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
